clk_div_multi: RTL and testbench
================================

# clk_div_multi

Multi-channel, runtime-programmable clock divider for the 50 MHz FPGA fabric clock. It produces NUM_CH independent divided clock enables/levels, each with an integer period set by parameter at reset and reprogrammable during operation without glitches or runt periods. Each channel also emits a single-cycle `tick` strobe per period, which downstream logic uses as a clock enable instead of a derived clock. The block sits at the top level, beside the board clock, and feeds display timing, UART baud generation and LED/PWM blocks.

## Interface
- `NUM_CH`, 4, number of independent divider channels (1..16)
- `CNT_W`, 32, width of the period counter and divisor
- `FPGA_CLK`, 50_000_000, input clock frequency in Hz
- `TARGET_FREQ`, 25_000_000, reset-time output frequency for every channel; reset divisor `DIV_RST = FPGA_CLK/TARGET_FREQ`, clamped to ≥2
- `clk` in 1: fabric clock; all logic on its rising edge
- `rst` in 1: reset, synchronous, active-high
- `en` in NUM_CH: per-channel run enable
- `wr_en` in 1: divisor write strobe
- `wr_ch` in $clog2(NUM_CH) (min 1): channel addressed by the write
- `wr_div` in CNT_W: new period in `clk` cycles
- `clk_div` out NUM_CH: divided square wave per channel
- `tick` out NUM_CH: one-cycle strobe on the last cycle of each period
- `pend` out NUM_CH: a written divisor is waiting for the period boundary

## Operation
- Per-channel state: `cnt` (0..D-1), active divisor D, pending divisor P, pending flag.
- Waveform for divisor D: `clk_div` is low for floor(D/2) cycles, then high for ceil(D/2) cycles. `tick`=1 only in the cycle where `cnt`=D-1. `cnt` wraps D-1→0.
- Divisor clamp: `wr_div` < 2 is stored as 2. No value of D can stop a running channel.
- Write: on `wr_en`=1, P←clamp(`wr_div`) and `pend[wr_ch]`←1. A `wr_ch` ≥ NUM_CH is ignored. Repeated writes before the boundary: the last one wins.
- Apply: the wrap out of a `tick` cycle loads D←P and clears `pend`. The new period starts at `cnt`=0, so no truncated or stretched period occurs.
- Write in the same cycle as `tick`: applied at that boundary. `pend` never becomes visibly set.
- `en`=0: `cnt`=0, `clk_div`=0, `tick`=0. A pending P is applied immediately (next cycle). On `en` 0→1, a full period starts at `cnt`=0.
- Channels are fully independent. They are phase-aligned only after a common reset or sync.

## Timing
- Reset values: `cnt`=0, D=`DIV_RST`, `pend`=0, `clk_div`=0, `tick`=0 for all channels. Reset overrides writes and `en`.
- All outputs are registered, with no combinational path from any input to any output.
- With `en` held at 1 through reset release, the first `clk` edge with `rst`=0 is period cycle 0.
- Write latency: `pend` is high the cycle after `wr_en`. The new D takes effect at the next boundary, which is at most D_old cycles away.
- `en` latency: outputs go to 0 the cycle after `en` falls.
- Reset mid-period: the partial period is discarded, and writes in that cycle are lost.

## Configuration
- `CLK_DIV_MULTI_SYNC_EN` defined:
  - Adds input `sync` (1 bit).
  - `sync`=1 forces every enabled channel to `cnt`=0 on the next cycle, with pending divisors applied and `tick` suppressed, so all channels are phase-aligned.
  - `sync` has priority over a write to the same channel: the write lands in P and stays pending.
- Macro undefined: no `sync` port and no sync logic. Alignment occurs only through reset.

## Structure
- Package `clk_div_pkg`:
  - constant `DIV_MIN`=2
  - function `div_from_freq(fpga_clk, target)` with clamp
  - typedef for the per-channel state record
- Sub-module `clk_div_ch`: one channel (counter, D/P registers, output registers). It is generated NUM_CH times.
- The top level does write decode and `wr_ch` range check only.

## Test plan
- Defaults (50 MHz→25 MHz, D=2), `en`=all ones, release reset → each `clk_div` is 0,1,0,1…, `tick` is high on every odd cycle, and `pend`=0.
- Ch0 `wr_div`=5 mid-period of D=2 → `pend[0]`=1 until the boundary, then `clk_div[0]` is 0,0,1,1,1 repeating and `tick` is high every 5th cycle; ch1–3 are unaffected.
- `wr_div`=0, then 1, then 4 on ch2 before the boundary → D=4 is applied (last wins), giving `clk_div[2]` 0,0,1,1; a lone `wr_div`=1 yields D=2.
- Write to ch1 coincident with `tick[1]` → the new D starts the next cycle and `pend[1]` never rises. `wr_ch`=NUM_CH → no channel changes.
- `en[3]`=0 for 7 cycles with a pending write → outputs are 0 and `pend[3]` clears within 1 cycle. Re-enable → a full period with the new D from `cnt`=0.
- `rst` pulsed mid-period on D=6 and D=9 channels → all outputs are 0 the next cycle, and D returns to `DIV_RST`. With `CLK_DIV_MULTI_SYNC_EN`, a `sync` pulse realigns D=3 and D=6 channels so their `tick`s coincide every 6 cycles.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants, reset-divisor helper and per-channel status record for clk_div_multi.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  // Registered per-channel status presented on the outputs
  typedef struct packed {
    logic pend;
    logic clk_div;
    logic tick;
  } ch_stat_t;

  function automatic int unsigned div_from_freq(input int unsigned fpga_clk,
                                                input int unsigned target);
    int unsigned d;
    d = (target == 0) ? DIV_MIN : fpga_clk / target;
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, active/pending divisor, registered clk_div/tick/pend.
// Latency: outputs registered, 1 cycle; no backpressure. Optional sync input under CLK_DIV_MULTI_SYNC_EN.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] DIV_RST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic             sync,
`endif
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_div,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pdiv;
  logic [CNT_W-1:0] wr_clamped;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_end;
  logic             do_sync;
  ch_stat_t         st;

  assign wr_clamped = (wr_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : wr_div;
  assign cnt_inc    = cnt + CNT_W'(1);
  assign at_end     = (cnt == div - CNT_W'(1));

`ifdef CLK_DIV_MULTI_SYNC_EN
  assign do_sync = sync;
`else
  assign do_sync = 1'b0;
`endif

  // Outputs are computed from the next count so they line up with cnt itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      div  <= DIV_RST;
      pdiv <= DIV_RST;
      st   <= '0;
    end else if (!en) begin
      cnt        <= '0;
      st.clk_div <= 1'b0;
      st.tick    <= 1'b0;
      if (wr) begin
        pdiv    <= wr_clamped;
        st.pend <= 1'b1;
      end else if (st.pend) begin
        div     <= pdiv;
        st.pend <= 1'b0;
      end
    end else if (do_sync) begin
      cnt        <= '0;
      st.clk_div <= 1'b0;
      st.tick    <= 1'b0;
      if (st.pend)
        div <= pdiv;
      // A write colliding with sync is kept for the following boundary
      if (wr) begin
        pdiv    <= wr_clamped;
        st.pend <= 1'b1;
      end else begin
        st.pend <= 1'b0;
      end
    end else if (at_end) begin
      cnt        <= '0;
      st.clk_div <= 1'b0;
      st.tick    <= 1'b0;
      div        <= wr ? wr_clamped : (st.pend ? pdiv : div);
      st.pend    <= 1'b0;
    end else begin
      cnt        <= cnt_inc;
      st.clk_div <= (cnt_inc >= (div >> 1));
      st.tick    <= (cnt_inc == div - CNT_W'(1));
      if (wr) begin
        pdiv    <= wr_clamped;
        st.pend <= 1'b1;
      end
    end
  end

  assign clk_div = st.clk_div;
  assign tick    = st.tick;
  assign pend    = st.pend;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent runtime-programmable clock dividers; top does write decode and channel range check.
// Latency: all outputs registered; no backpressure. Optional sync port under CLK_DIV_MULTI_SYNC_EN.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned FPGA_CLK    = 50_000_000,
  parameter int unsigned TARGET_FREQ = 25_000_000,
  localparam int         WR_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic              sync,
`endif
  input  logic              wr_en,
  input  logic [WR_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(div_from_freq(FPGA_CLK, TARGET_FREQ));

  logic              wr_ok;
  logic [NUM_CH-1:0] wr_sel;

  assign wr_ok = wr_en && (int'(wr_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_sel[i] = wr_ok && (int'(wr_ch) == i);

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
`ifdef CLK_DIV_MULTI_SYNC_EN
      .sync    (sync),
`endif
      .wr      (wr_sel[i]),
      .wr_div  (wr_div),
      .clk_div (clk_div[i]),
      .tick    (tick[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a period-position reference model predicts every output cycle.
module tb_clk_div_multi;

  localparam int NCH = 5;
  localparam int unsigned DIV_RST_EXP = 2;
`ifdef CLK_DIV_MULTI_SYNC_EN
  localparam bit HAS_SYNC = 1'b1;
`else
  localparam bit HAS_SYNC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] en = '1;
  logic           sync_i = 1'b0;
  logic           wr_en = 1'b0;
  logic [2:0]     wr_ch = '0;
  logic [31:0]    wr_div = '0;
  logic [NCH-1:0] clk_div, tick, pend;

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(32), .FPGA_CLK(50_000_000), .TARGET_FREQ(25_000_000)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
`ifdef CLK_DIV_MULTI_SYNC_EN
    .sync    (sync_i),
`endif
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .clk_div (clk_div),
    .tick    (tick),
    .pend    (pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] cd;
    logic [NCH-1:0] tk;
    logic [NCH-1:0] pd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference state: position within the current period, active/pending period length
  int unsigned m_pos[NCH];
  int unsigned m_d[NCH];
  int unsigned m_p[NCH];
  bit          m_pend[NCH];

  function automatic exp_t model(input bit r, input logic [NCH-1:0] e, input bit we,
                                 input int unsigned wc, input int unsigned wd, input bit s);
    exp_t x;
    int unsigned cl;
    bit w;
    cl = (wd < 2) ? 2 : wd;
    for (int c = 0; c < NCH; c++) begin
      w = we && (wc == c);
      if (r) begin
        m_pos[c] = 0; m_d[c] = DIV_RST_EXP; m_pend[c] = 0;
      end else if (!e[c]) begin
        m_pos[c] = 0;
        if (w) begin m_p[c] = cl; m_pend[c] = 1; end
        else if (m_pend[c]) begin m_d[c] = m_p[c]; m_pend[c] = 0; end
      end else if (s && HAS_SYNC) begin
        if (m_pend[c]) m_d[c] = m_p[c];
        m_pend[c] = w;
        if (w) m_p[c] = cl;
        m_pos[c] = 0;
      end else if (m_pos[c] + 1 == m_d[c]) begin
        if (w) m_d[c] = cl;
        else if (m_pend[c]) m_d[c] = m_p[c];
        m_pend[c] = 0;
        m_pos[c] = 0;
      end else begin
        m_pos[c]++;
        if (w) begin m_p[c] = cl; m_pend[c] = 1; end
      end
      // Low for the first floor(D/2) positions, high for the rest; tick on the last
      x.cd[c] = (m_pos[c] >= m_d[c] / 2);
      x.tk[c] = (m_pos[c] + 1 == m_d[c]);
      x.pd[c] = m_pend[c];
    end
    return x;
  endfunction

  task automatic step(input bit r, input logic [NCH-1:0] e, input bit we,
                      input int unsigned wc, input int unsigned wd, input bit s);
    @(negedge clk);
    rst = r; en = e; wr_en = we; wr_ch = 3'(wc); wr_div = wd; sync_i = s;
    q.push_back(model(r, e, we, wc, wd, s));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '1, 0, 0, 0, 0);
  endtask

  task automatic wr(input int unsigned ch, input int unsigned d);
    step(0, '1, 1, ch, d, 0);
  endtask

  // Monitor: DUT presents a fresh output vector every cycle
  always @(posedge clk) begin
    exp_t x;
    #2;
    cyc++;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (clk_div !== x.cd || tick !== x.tk || pend !== x.pd) begin
        errors++;
        $display("FAIL outputs cyc=%0d got clk_div=%b tick=%b pend=%b want clk_div=%b tick=%b pend=%b",
                 cyc, clk_div, tick, pend, x.cd, x.tk, x.pd);
      end
    end
  end

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_pos[c] = 0; m_d[c] = DIV_RST_EXP; m_p[c] = DIV_RST_EXP; m_pend[c] = 0;
    end
    // Reset, then free-running defaults
    for (int k = 0; k < 3; k++) step(1, '1, 0, 0, 0, 0);
    idle(8);
    // Ch0 to 5 mid-period
    wr(0, 5); idle(16);
    // Last write wins, clamp of 0/1
    wr(2, 0); wr(2, 1); wr(2, 4); idle(12);
    wr(2, 1); idle(8);
    // Write to ch1 on its tick cycle
    wr(1, 3); idle(4);
    for (int k = 0; k < 20 && (m_pos[1] + 1 != m_d[1]); k++) idle(1);
    wr(1, 7); idle(10);
    // Out-of-range channel addresses
    wr(5, 9); wr(6, 3); wr(7, 11); idle(4);
    // Disable ch3 with a pending divisor, then re-enable
    wr(3, 7);
    for (int k = 0; k < 7; k++) step(0, 5'b10111, 0, 0, 0, 0);
    idle(16);
    // Reset mid-period on long divisors
    wr(0, 6); wr(4, 9); idle(20);
    step(1, '1, 1, 0, 3, 0); idle(8);
    // Sync realignment of 3- and 6-cycle channels
    wr(0, 3); wr(1, 6); idle(13);
    step(0, '1, 1, 1, 6, 1); idle(20);
    // Randomized traffic
    for (int k = 0; k < 2500; k++) begin
      logic [NCH-1:0] e;
      for (int c = 0; c < NCH; c++) e[c] = ($urandom_range(0, 7) != 0);
      step($urandom_range(0, 199) == 0, e, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 49) == 0);
    end
    @(posedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
